// File: rtl/brief_pkg.sv
// brief_pkg: shared types, FSM states and rounding helper for the rotated-BRIEF engine
package brief_pkg;
   localparam int TRIG_FRAC_DEF = 10;
   typedef struct packed {
      logic signed [7:0] xa;
      logic signed [7:0] ya;
      logic signed [7:0] xb;
      logic signed [7:0] yb;
   } pattern_pair_t;
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT, S_SKIP} state_t;
   function automatic int round_half_away(int v, int frac);
      int h = 1 << (frac - 1);
      return v < 0 ? -((h - v) >>> frac) : (v + h) >>> frac;
   endfunction
endpackage

// File: rtl/brief_serial_desc_if.sv
// brief_serial_desc_if: keypoint request and descriptor response bundle
interface brief_serial_desc_if #(
   parameter int NBITS = 256,
   parameter int RADIUS = 15,
   parameter int TRIG_W = 12,
   parameter int CW = 10,
   parameter int DEPTH_W = 16
);
   localparam int WIN = 2 * RADIUS + 1;
   logic i_valid, o_ready, i_upright, i_flush, o_valid, i_ready;
   logic [7:0] i_window [WIN][WIN];
   logic [CW-1:0] i_coor_x, i_coor_y, o_coor_x, o_coor_y;
   logic [7:0] i_score, o_score;
   logic [DEPTH_W-1:0] i_depth, o_depth;
   logic signed [TRIG_W-1:0] i_sin, i_cos;
   logic [NBITS-1:0] o_descriptor;
   modport slave (
      input i_valid, i_window, i_coor_x, i_coor_y, i_score, i_depth, i_sin, i_cos, i_upright, i_flush, i_ready,
      output o_ready, o_valid, o_coor_x, o_coor_y, o_score, o_depth, o_descriptor
   );
   modport master (
      output i_valid, i_window, i_coor_x, i_coor_y, i_score, i_depth, i_sin, i_cos, i_upright, i_flush, i_ready,
      input o_ready, o_valid, o_coor_x, o_coor_y, o_score, o_depth, o_descriptor
   );
endinterface

// File: rtl/brief_pattern_rom.sv
// brief_pattern_rom: LANES-wide read of the fixed point-pair sampling pattern
module brief_pattern_rom import brief_pkg::*; #(
   parameter int NBITS = 256,
   parameter int LANES = 32,
   parameter int GW = 3
) (
   input  logic [GW-1:0] grp,
   output pattern_pair_t pairs [LANES]
);
   localparam int IW = $clog2(NBITS);
   function automatic pattern_pair_t pair_at(int k);
      case (k)
         0: return '{-8'sd3, 8'sd0, 8'sd4, 8'sd0};
         1: return '{8'sd4, 8'sd0, -8'sd3, 8'sd0};
         2: return '{8'sd5, 8'sd0, 8'sd0, 8'sd0};
         3: return '{8'sd0, -8'sd20, 8'sd20, 8'sd0};
         default: return '{8'((k * 7 + 3) % 31 - 15), 8'((k * 13 + 5) % 31 - 15),
                           8'((k * 11 + 1) % 31 - 15), 8'((k * 17 + 9) % 31 - 15)};
      endcase
   endfunction
   pattern_pair_t rom [NBITS];
   for (genvar k = 0; k < NBITS; k++) begin : g_rom
      assign rom[k] = pair_at(k);
   end
   always_comb
      for (int l = 0; l < LANES; l++)
         pairs[l] = rom[IW'(int'(grp) * LANES + l)];
endmodule

// File: rtl/brief_serial_desc.sv
// brief_serial_desc: rotated-BRIEF descriptor engine, LANES pair tests per cycle
module brief_serial_desc import brief_pkg::*; #(
   parameter int NBITS = 256,
   parameter int LANES = 32,
   parameter int RADIUS = 15,
   parameter int TRIG_W = 12,
   parameter int TRIG_FRAC = TRIG_FRAC_DEF,
   parameter int CW = 10,
   parameter int DEPTH_W = 16
) (
   input logic i_clk,
   input logic i_rst_n,
   brief_serial_desc_if.slave bus
);
   localparam int WIN = 2 * RADIUS + 1;
   localparam int G = NBITS / LANES;
   localparam int GW = G > 1 ? $clog2(G) : 1;
   localparam int PW = 8 + TRIG_W;
   localparam int CB = $clog2(WIN);
   state_t st, nxt;
   logic [GW-1:0] grp, g1, g2;
   logic v1, v2, accept;
   logic signed [TRIG_W-1:0] sin_q, cos_q;
   pattern_pair_t pairs [LANES];
   logic signed [PW-1:0] xc [LANES][2], ys [LANES][2], xs [LANES][2], yc [LANES][2];
   logic [CB-1:0] px [LANES][2], py [LANES][2];
   logic [LANES-1:0] bits;
   function automatic logic [CB-1:0] to_pix(int v);
      int c = round_half_away(v, TRIG_FRAC) + RADIUS;
      return CB'(c < 0 ? 0 : c > WIN - 1 ? WIN - 1 : c);
   endfunction
   brief_pattern_rom #(.NBITS(NBITS), .LANES(LANES), .GW(GW)) u_rom (.grp(grp), .pairs(pairs));
   assign accept = st == S_IDLE && bus.i_valid && !bus.i_flush;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         st <= S_IDLE;
         grp <= '0;
      end else begin
         st <= nxt;
         grp <= st != nxt ? '0 : grp + 1'b1;
      end
   always_comb begin
      nxt = st;
      case (st)
         S_IDLE:  if (bus.i_valid) nxt = (bus.i_coor_x == '0 || bus.i_coor_y == '0) ? S_SKIP : S_RUN;
         S_RUN:   if (grp == GW'(G - 1)) nxt = S_DRAIN;
         S_DRAIN: if (grp == GW'(1)) nxt = S_OUT;
         S_OUT:   if (bus.i_ready) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      if (bus.i_flush) nxt = S_IDLE;
   end
   always_comb begin
      bus.o_ready = st == S_IDLE;
      bus.o_valid = st == S_OUT;
   end
   // stage 1 holds the eight products per lane, stage 2 the clamped sample positions
   always_ff @(posedge i_clk)
      for (int l = 0; l < LANES; l++)
         for (int p = 0; p < 2; p++) begin
            xc[l][p] <= PW'(p != 0 ? pairs[l].xb : pairs[l].xa) * PW'(cos_q);
            xs[l][p] <= PW'(p != 0 ? pairs[l].xb : pairs[l].xa) * PW'(sin_q);
            ys[l][p] <= PW'(p != 0 ? pairs[l].yb : pairs[l].ya) * PW'(sin_q);
            yc[l][p] <= PW'(p != 0 ? pairs[l].yb : pairs[l].ya) * PW'(cos_q);
            px[l][p] <= to_pix(int'(xc[l][p]) - int'(ys[l][p]));
            py[l][p] <= to_pix(int'(xs[l][p]) + int'(yc[l][p]));
         end
   always_comb begin
      bits = '0;
      for (int l = 0; l < LANES; l++)
         bits[l] = bus.i_window[py[l][0]][px[l][0]] > bus.i_window[py[l][1]][px[l][1]];
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         {v1, v2, g1, g2, sin_q, cos_q} <= '0;
         {bus.o_coor_x, bus.o_coor_y, bus.o_score, bus.o_depth, bus.o_descriptor} <= '0;
      end else begin
         v1 <= st == S_RUN && !bus.i_flush;
         v2 <= v1 && !bus.i_flush;
         g1 <= grp;
         g2 <= g1;
         if (accept) begin
            bus.o_coor_x <= bus.i_coor_x;
            bus.o_coor_y <= bus.i_coor_y;
            bus.o_score <= bus.i_score;
            bus.o_depth <= bus.i_depth;
            sin_q <= bus.i_upright ? '0 : bus.i_sin;
            cos_q <= bus.i_upright ? TRIG_W'(1 << TRIG_FRAC) : bus.i_cos;
         end
         if (bus.i_flush || accept) bus.o_descriptor <= '0;
         else if (v2) bus.o_descriptor[int'(g2) * LANES +: LANES] <= bits;
      end
endmodule

// File: tb/tb_brief_serial_desc.sv
// tb_brief_serial_desc: directed vectors and corner sequences for brief_serial_desc
module tb_brief_serial_desc;
   localparam int NB = 256;
   typedef struct packed { int xa, ya, xb, yb; } pp_t;
   typedef struct { int up, sn, cs, wm, cx, cy, bk, out, bv; } vec_t;
   logic clk = 1'b0, rst_n = 1'b0;
   int errs = 0, checks = 0;
   vec_t vecs [9];
   always #5 clk = ~clk;
   brief_serial_desc_if #(.NBITS(NB)) b0 (), b1 (), b2 ();
   brief_serial_desc #(.LANES(32))  dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));
   brief_serial_desc #(.LANES(256)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
   brief_serial_desc #(.LANES(1))   dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));
   assign b1.i_window = b0.i_window;
   assign b2.i_window = b0.i_window;
   assign {b1.i_coor_x, b1.i_coor_y, b1.i_score, b1.i_depth, b1.i_sin, b1.i_cos, b1.i_upright} =
          {b0.i_coor_x, b0.i_coor_y, b0.i_score, b0.i_depth, b0.i_sin, b0.i_cos, b0.i_upright};
   assign {b2.i_coor_x, b2.i_coor_y, b2.i_score, b2.i_depth, b2.i_sin, b2.i_cos, b2.i_upright} =
          {b0.i_coor_x, b0.i_coor_y, b0.i_score, b0.i_depth, b0.i_sin, b0.i_cos, b0.i_upright};

   function automatic int pix(int wm, int x, int y);
      return wm == 0 ? x : wm == 1 ? y * 8 : wm == 2 ? x * 8 : (x * 37 + y * 91 + x * y * 13) & 255;
   endfunction
   function automatic pp_t pat(int k);
      case (k)
         0: return '{-3, 0, 4, 0};
         1: return '{4, 0, -3, 0};
         2: return '{5, 0, 0, 0};
         3: return '{0, -20, 20, 0};
         default: return '{(k * 7 + 3) % 31 - 15, (k * 13 + 5) % 31 - 15, (k * 11 + 1) % 31 - 15, (k * 17 + 9) % 31 - 15};
      endcase
   endfunction
   function automatic int rnd(int n);
      real r = n / 1024.0;
      return r >= 0.0 ? int'($floor(r + 0.5)) : -int'($floor(0.5 - r));
   endfunction
   function automatic int cl(int v);
      return v < 0 ? 0 : v > 30 ? 30 : v;
   endfunction
   function automatic logic [NB-1:0] golden(int up, int sn, int cs, int wm);
      logic [NB-1:0] d = '0;
      int s = up != 0 ? 0 : sn;
      int c = up != 0 ? 1024 : cs;
      for (int k = 0; k < NB; k++) begin
         pp_t p;
         int ax, ay, bx, by;
         p = pat(k);
         ax = cl(rnd(p.xa * c - p.ya * s) + 15);
         ay = cl(rnd(p.xa * s + p.ya * c) + 15);
         bx = cl(rnd(p.xb * c - p.yb * s) + 15);
         by = cl(rnd(p.xb * s + p.yb * c) + 15);
         d[k] = pix(wm, ax, ay) > pix(wm, bx, by);
      end
      return d;
   endfunction

   task automatic chk(string nm, logic [NB-1:0] act, logic [NB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic fill(int wm);
      for (int y = 0; y < 31; y++)
         for (int x = 0; x < 31; x++)
            b0.i_window[y][x] = 8'(pix(wm, x, y));
   endtask
   task automatic req(int up, int sn, int cs, int cx, int cy, int sc, int dp);
      b0.i_upright = up != 0;
      b0.i_sin = 12'(sn);
      b0.i_cos = 12'(cs);
      b0.i_coor_x = 10'(cx);
      b0.i_coor_y = 10'(cy);
      b0.i_score = 8'(sc);
      b0.i_depth = 16'(dp);
   endtask
   task automatic go();
      b0.i_valid = 1'b1;
      @(posedge clk);
      #1 b0.i_valid = 1'b0;
   endtask
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!b0.o_valid && lat < 400) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   initial begin
      int lat, l0, l1, l2;
      logic seen;
      logic [43:0] sd, snap_sd;
      logic [NB-1:0] g, d0, d1, d2, snap;
      {b0.i_valid, b0.i_flush, b0.i_ready} = 3'b001;
      {b1.i_valid, b1.i_flush, b1.i_ready} = 3'b001;
      {b2.i_valid, b2.i_flush, b2.i_ready} = 3'b001;
      req(0, 0, 1024, 1, 1, 0, 0);
      fill(0);
      vecs[0] = '{1, 300, -500, 0, 100, 50, 0, 1, 0};
      vecs[1] = '{1, 0, 1024, 0, 100, 50, 1, 1, 1};
      vecs[2] = '{0, 1024, 0, 1, 7, 9, 2, 1, 1};
      vecs[3] = '{0, 1024, 0, 2, 7, 9, 3, 1, 1};
      vecs[4] = '{0, 724, 724, 3, 512, 300, -1, 1, 0};
      vecs[5] = '{0, -600, -830, 3, 1023, 1023, -1, 1, 0};
      vecs[6] = '{0, 300, 900, 3, 0, 40, -1, 0, 0};
      vecs[7] = '{0, 300, 900, 3, 40, 0, -1, 0, 0};
      vecs[8] = '{1, 300, 900, 3, 5, 6, -1, 1, 0};
      #12;
      chk("rst_hs", NB'({b0.o_valid, b0.o_ready}), NB'(2'b01));
      chk("rst_desc", b0.o_descriptor, '0);
      chk("rst_side", NB'({b0.o_coor_x, b0.o_coor_y, b0.o_score, b0.o_depth}), '0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++) begin
         fill(vecs[i].wm);
         req(vecs[i].up, vecs[i].sn, vecs[i].cs, vecs[i].cx, vecs[i].cy, i * 17 + 3, i * 1000 + 7);
         sd = {10'(vecs[i].cx), 10'(vecs[i].cy), 8'(i * 17 + 3), 16'(i * 1000 + 7)};
         g = golden(vecs[i].up, vecs[i].sn, vecs[i].cs, vecs[i].wm);
         go();
         if (vecs[i].out != 0) begin
            wait_valid(lat);
            chk($sformatf("v%0d_latency", i), NB'(lat), NB'(10));
            chk($sformatf("v%0d_desc", i), b0.o_descriptor, g);
            chk($sformatf("v%0d_side", i), NB'({b0.o_coor_x, b0.o_coor_y, b0.o_score, b0.o_depth}), NB'(sd));
            if (vecs[i].bk >= 0)
               chk($sformatf("v%0d_bit%0d", i, vecs[i].bk), NB'(b0.o_descriptor[vecs[i].bk]), NB'(vecs[i].bv));
            @(posedge clk);
            #1 chk($sformatf("v%0d_done", i), NB'({b0.o_valid, b0.o_ready}), NB'(2'b01));
         end else begin
            chk($sformatf("v%0d_skip_busy", i), NB'(b0.o_ready), '0);
            @(posedge clk);
            #1 chk($sformatf("v%0d_skip_back", i), NB'(b0.o_ready), NB'(1));
            seen = 1'b0;
            repeat (12) begin
               @(posedge clk);
               #1 seen |= b0.o_valid;
            end
            chk($sformatf("v%0d_skip_novalid", i), NB'(seen), '0);
         end
      end

      fill(3);
      req(0, 500, 900, 3, 4, 77, 4242);
      g = golden(0, 500, 900, 3);
      b0.i_ready = 1'b0;
      go();
      wait_valid(lat);
      snap = b0.o_descriptor;
      snap_sd = {b0.o_coor_x, b0.o_coor_y, b0.o_score, b0.o_depth};
      chk("stall_desc", snap, g);
      req(0, 0, 0, 999, 999, 1, 1);
      repeat (5) begin
         @(posedge clk);
         #1 chk("stall_hs", NB'({b0.o_valid, b0.o_ready}), NB'(2'b10));
         chk("stall_hold", b0.o_descriptor, g);
         chk("stall_side", NB'({b0.o_coor_x, b0.o_coor_y, b0.o_score, b0.o_depth}), NB'({10'd3, 10'd4, 8'd77, 16'd4242}));
      end
      b0.i_ready = 1'b1;
      @(posedge clk);
      #1 chk("stall_release", NB'({b0.o_valid, b0.o_ready}), NB'(2'b01));

      req(0, 500, 900, 3, 4, 77, 4242);
      go();
      repeat (3) @(posedge clk);
      #1 chk("partial_desc", b0.o_descriptor, g & NB'(32'hffff_ffff));
      #1 rst_n = 1'b0;
      #1 chk("arst_hs", NB'({b0.o_valid, b0.o_ready}), NB'(2'b01));
      chk("arst_desc", b0.o_descriptor, '0);
      chk("arst_side", NB'({b0.o_coor_x, b0.o_coor_y, b0.o_score, b0.o_depth}), '0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 b0.i_ready = 1'b0;
      go();
      wait_valid(lat);
      chk("flush_pre", b0.o_descriptor, g);
      b0.i_flush = 1'b1;
      b0.i_ready = 1'b1;
      @(posedge clk);
      #1 chk("flush_hs", NB'({b0.o_valid, b0.o_ready}), NB'(2'b01));
      chk("flush_desc", b0.o_descriptor, '0);
      b0.i_valid = 1'b1;
      @(posedge clk);
      #1 chk("flush_blocks_accept", NB'({b0.o_valid, b0.o_ready}), NB'(2'b01));
      b0.i_valid = 1'b0;
      b0.i_flush = 1'b0;

      fill(3);
      req(0, -700, 700, 11, 12, 9, 99);
      g = golden(0, -700, 700, 3);
      {l0, l1, l2} = {-1, -1, -1};
      {d0, d1, d2} = '0;
      {b0.i_valid, b1.i_valid, b2.i_valid} = 3'b111;
      @(posedge clk);
      #1 {b0.i_valid, b1.i_valid, b2.i_valid} = 3'b000;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk);
         #1;
         if (b0.o_valid && l0 < 0) begin l0 = n; d0 = b0.o_descriptor; end
         if (b1.o_valid && l1 < 0) begin l1 = n; d1 = b1.o_descriptor; end
         if (b2.o_valid && l2 < 0) begin l2 = n; d2 = b2.o_descriptor; end
      end
      chk("lanes32_latency", NB'(l0), NB'(10));
      chk("lanes256_latency", NB'(l1), NB'(3));
      chk("lanes1_latency", NB'(l2), NB'(258));
      chk("lanes32_desc", d0, g);
      chk("lanes256_desc", d1, g);
      chk("lanes1_desc", d2, g);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
